// File: rtl/counter_drv_pkg.sv
// rtl/counter_drv_pkg.sv - shared command/state encodings and default widths for the counter driver
package counter_drv_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_COUNT = 2'b01,
        OP_HOLD  = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10,
        ST_HOLD  = 2'b11
    } drv_state_e;

endpackage

// File: rtl/counter_ref_model.sv
// rtl/counter_ref_model.sv - expected-value counter model, comparator and saturating error count
module counter_ref_model
    import counter_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] exp_count,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    logic [WIDTH-1:0] exp_count_q, exp_count_d;
    logic             synced_q, synced_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        exp_count_d = exp_count_q;
        synced_d    = synced_q;
        mismatch_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (load) begin
            exp_count_d = data;
            synced_d    = 1'b1;
        end else if (enable) begin
            exp_count_d = exp_count_q + WIDTH'(1);
        end
        // Compare only once a LOAD has given the model a known starting point.
        if (synced_q && (cout != exp_count_q)) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_count_q <= '0;
            synced_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            exp_count_q <= exp_count_d;
            synced_q    <= synced_d;
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign exp_count = exp_count_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/counter_cmd_driver.sv
// rtl/counter_cmd_driver.sv - command-driven load/enable sequencer for an external counter with checking
module counter_cmd_driver
    import counter_drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             load,
    output logic             enable,
    output logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] cout,
    output logic [WIDTH-1:0] exp_count,
    output logic             mismatch,
    output logic             bad_cmd,
    output logic [ERR_W-1:0] err_cnt,
    output logic             busy
);

    drv_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             bad_cmd_q, bad_cmd_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            bad_cmd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            bad_cmd_q <= bad_cmd_d;
        end
    end

    // load/enable are decoded from state so an async reset removes them at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        bad_cmd_d = 1'b0;
        cmd_ready = 1'b0;
        load      = 1'b0;
        enable    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        OP_LOAD: begin
                            data_d  = cmd_arg;
                            state_d = ST_LOAD;
                        end
                        OP_COUNT: begin
                            cnt_d   = cmd_arg;
                            state_d = ST_COUNT;
                        end
                        OP_HOLD: begin
                            cnt_d   = cmd_arg;
                            state_d = ST_HOLD;
                        end
                        default: bad_cmd_d = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_COUNT: begin
                enable = (cnt_q != '0);
                if (cnt_q <= WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q <= WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data    = data_q;
    assign bad_cmd = bad_cmd_q;
    assign busy    = (state_q != ST_IDLE);

    counter_ref_model #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_ref_model (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .enable    (enable),
        .data      (data_q),
        .cout      (cout),
        .exp_count (exp_count),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
    );

endmodule

// File: doc/counter_cmd_driver.md
COUNTER_CMD_DRIVER -- requirements
Module: counter_cmd_driver

Interface
REQ-001 Parameter: WIDTH, default 8, counter data/output width.
REQ-002 Parameter: ERR_W, default 8, error counter width.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  in  1  command offered.
REQ-006 Port: cmd_ready  out  1  driver accepts command this cycle.
REQ-007 Port: cmd_op  in  2  00=LOAD, 01=COUNT, 10=HOLD, 11=reserved.
REQ-008 Port: cmd_arg  in  WIDTH  LOAD value, or COUNT/HOLD cycle count.
REQ-009 Port: load  out  1  counter load strobe.
REQ-010 Port: enable  out  1  counter count enable.
REQ-011 Port: data  out  WIDTH  counter load value.
REQ-012 Port: cout  in  WIDTH  observed counter output.
REQ-013 Port: exp_count  out  WIDTH  expected counter value.
REQ-014 Port: mismatch  out  1  one-cycle pulse on compare failure.
REQ-015 Port: bad_cmd  out  1  one-cycle pulse on reserved op accepted.
REQ-016 Port: err_cnt  out  ERR_W  saturating mismatch count.
REQ-017 Port: busy  out  1  high whenever FSM is not IDLE.

Function
REQ-018 FSM states: IDLE, LOAD, COUNT, HOLD; cmd_ready SHALL equal (state==IDLE).
REQ-019 Handshake: command accepted on cycle with cmd_valid && cmd_ready; op and arg registered at acceptance.
REQ-020 IDLE: accept op 00 -> LOAD; 01 -> COUNT; 10 -> HOLD; 11 -> stay IDLE, bad_cmd pulses next cycle.
REQ-021 LOAD: exactly one cycle with load=1, enable=0, data=arg; then IDLE.
REQ-022 COUNT: enable=1, load=0 for exactly arg cycles; arg=0 -> no enable cycle, return to IDLE next cycle.
REQ-023 HOLD: load=0, enable=0 for arg cycles (arg=0 -> immediate IDLE); then IDLE.
REQ-024 Outside LOAD, load=0 and data holds its last driven value; outside COUNT, enable=0.
REQ-025 Consequence: minimum one IDLE cycle between consecutive commands.
REQ-026 Model: on each edge, if load then exp_count<=data, else if enable then exp_count<=exp_count+1 mod 2^WIDTH (load priority).
REQ-027 Compare armed (synced=1) from the edge of the first LOAD cycle after reset; unarmed -> no compare.
REQ-028 When armed, each cycle cout!=exp_count SHALL register mismatch=1 for the following cycle only.
REQ-029 err_cnt increments on each mismatch, saturating at 2^ERR_W-1.
REQ-030 Wrap: COUNT across 2^WIDTH-1 -> exp_count wraps to 0 with no mismatch for a correct counter.

Reset
REQ-031 On reset assertion, immediately: state=IDLE, load=0, enable=0, data=0, exp_count=0, mismatch=0, bad_cmd=0, err_cnt=0, synced=0, busy=0.
REQ-032 Reset mid-command SHALL abort it; no residual enable/load cycle after deassertion.
REQ-033 cmd_ready=1 on the first cycle after reset deassertion.

Structure
REQ-034 Package counter_drv_pkg SHALL hold cmd_op enum, FSM state enum and default WIDTH/ERR_W constants.
REQ-035 Sub-module counter_ref_model SHALL hold exp_count, synced, comparator, mismatch and err_cnt; FSM stays in top.

Verification
REQ-036 LOAD 0x5A then COUNT 3 -> load 1 cycle data=0x5A, enable 3 cycles, exp_count=0x5D, mismatch never set.
REQ-037 LOAD 0xFE, COUNT 4 -> exp_count sequence FF,00,01,02; ends 0x02, no mismatch.
REQ-038 COUNT 0 and HOLD 0 -> no enable pulse, busy 1 cycle, cmd_ready back next cycle.
REQ-039 Counter stub stuck-at cout=0x00 after LOAD 0x10 -> mismatch pulses, err_cnt increments per cycle, saturates at 255.
REQ-040 Reset asserted in 2nd cycle of COUNT 10 -> enable drops same cycle, all outputs 0, cmd_ready=1 after release.
REQ-041 Op 11 with cmd_arg 0x33 -> bad_cmd one pulse, load/enable stay 0, exp_count unchanged.
